axis_frame_source: RTL and testbench

- AXI4-Stream master that generates numbered test frames with a deterministic data pattern.
- Transmit-side counterpart of the team's AXI-Stream sink checker; drives FIFO/DUT inputs in simulation benches and on-chip loopback tests.
- Software/bench triggers a burst of N frames of a programmable byte length. The block honours backpressure, marks start of frame on tuser and end of frame on tlast, and reports completion.

---
 rtl/axis_frame_source.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_axis_frame_source.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_source.sv
// axis_frame_source: AXI4-Stream master that emits bursts of numbered test
// frames. tdata = {frame_idx, beat_idx}, tuser[0] marks SOF, tlast marks EOF,
// and the last beat carries a partial tkeep when the length is not a whole
// number of beats.
// Optional feature: define AXIS_SRC_THROTTLE_EN to gate new beats with a
// 16-bit Galois LFSR, which creates pseudo-random tvalid gaps.
module axis_frame_source #(
    parameter int          DATA_W     = 32,
    parameter int          KEEP_W     = DATA_W / 8,
    parameter int          USER_W     = 1,
    parameter int          IFG_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [15:0]       num_frames,
    input  logic [15:0]       frame_bytes,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frames_sent,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [USER_W-1:0] m_axis_tuser
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [16:0]       KEEP_W17 = 17'(KEEP_W);
    localparam logic [15:0]       GAP_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
    localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

    // Byte enables for the final beat: rem LSB ones, all ones when rem is 0.
    function automatic logic [KEEP_W-1:0] last_keep_f(input logic [16:0] rem);
        logic [KEEP_W-1:0] k;
        for (int i = 0; i < KEEP_W; i++) begin
            k[i] = (rem == 17'd0) || (17'(i) < rem);
        end
        return k;
    endfunction

    // {frame, beat} zero-extended (or truncated) to the bus width.
    function automatic logic [DATA_W-1:0] pattern_f(input logic [15:0] f, input logic [15:0] b);
        logic [31:0]       p;
        logic [DATA_W-1:0] d;
        p = {f, b};
        for (int i = 0; i < DATA_W; i++) begin
            if (i < 32) begin
                d[i] = p[i[4:0]];
            end else begin
                d[i] = 1'b0;
            end
        end
        return d;
    endfunction

    state_t            state_r, state_nx;
    logic              tvalid_r, tvalid_nx;
    logic [DATA_W-1:0] tdata_r, tdata_nx;
    logic [KEEP_W-1:0] tkeep_r, tkeep_nx;
    logic              tlast_r, tlast_nx;
    logic [USER_W-1:0] tuser_r, tuser_nx;
    logic              busy_r, busy_nx;
    logic              done_r, done_nx;
    logic [15:0]       frames_sent_r, frames_sent_nx;
    logic [15:0]       num_frames_r, num_frames_nx;
    logic [15:0]       beats_r, beats_nx;
    logic [KEEP_W-1:0] last_keep_r, last_keep_nx;
    logic [15:0]       frame_idx_r, frame_idx_nx;
    logic [15:0]       beat_idx_r, beat_idx_nx;
    logic [15:0]       gap_cnt_r, gap_cnt_nx;

    logic              hs_s, last_hs_s, final_s, load_s, is_last_s, throttle_ok_s, accept_s;
    logic [16:0]       fb_s, beats17_s, rem_s;

    assign hs_s      = tvalid_r && m_axis_tready;
    assign last_hs_s = hs_s && tlast_r;
    assign final_s   = (frames_sent_r + 16'd1) == num_frames_r;
    assign is_last_s = beat_idx_r == (beats_r - 16'd1);
    assign accept_s  = (state_r == ST_IDLE) && start && !done_r;
    assign fb_s      = (frame_bytes == 16'd0) ? KEEP_W17 : {1'b0, frame_bytes};
    assign beats17_s = (fb_s + KEEP_W17 - 17'd1) / KEEP_W17;
    assign rem_s     = fb_s % KEEP_W17;

`ifdef AXIS_SRC_THROTTLE_EN
    logic [15:0] lfsr_r;

    // Galois LFSR (taps 16,14,13,11) stepping every cycle; bit 0 permits a new beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign throttle_ok_s = lfsr_r[0];
`else
    logic [15:0] unused_seed_s;
    assign unused_seed_s = LFSR_SEED;
    assign throttle_ok_s = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx = (num_frames == 16'd0) ? ST_FIN : ST_SEND;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (last_hs_s) begin
                    if (final_s) begin
                        state_nx = ST_FIN;
                    end else if (IFG_CYCLES == 0) begin
                        state_nx = ST_SEND;
                    end else begin
                        state_nx = ST_GAP;
                    end
                end else begin
                    state_nx = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nx = ST_SEND;
                end else begin
                    state_nx = ST_GAP;
                end
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of outputs, config and counters; a beat is loaded into the
    // output register only when the slot is free (nothing pending or handshaking).
    always_comb begin
        load_s         = 1'b0;
        tvalid_nx      = tvalid_r;
        tdata_nx       = tdata_r;
        tkeep_nx       = tkeep_r;
        tlast_nx       = tlast_r;
        tuser_nx       = tuser_r;
        busy_nx        = busy_r;
        done_nx        = 1'b0;
        frames_sent_nx = frames_sent_r;
        num_frames_nx  = num_frames_r;
        beats_nx       = beats_r;
        last_keep_nx   = last_keep_r;
        frame_idx_nx   = frame_idx_r;
        beat_idx_nx    = beat_idx_r;
        gap_cnt_nx     = 16'd0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    num_frames_nx  = num_frames;
                    beats_nx       = beats17_s[15:0];
                    last_keep_nx   = last_keep_f(rem_s);
                    frames_sent_nx = 16'd0;
                    frame_idx_nx   = 16'd0;
                    beat_idx_nx    = 16'd0;
                    busy_nx        = 1'b1;
                end else begin
                    busy_nx = busy_r;
                end
            end
            ST_SEND: begin
                if (last_hs_s) begin
                    frames_sent_nx = frames_sent_r + 16'd1;
                end else begin
                    frames_sent_nx = frames_sent_r;
                end
                if (!tvalid_r || hs_s) begin
                    if (last_hs_s && (final_s || (IFG_CYCLES != 0))) begin
                        load_s = 1'b0;
                    end else begin
                        load_s = throttle_ok_s;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_GAP: begin
                gap_cnt_nx = gap_cnt_r + 16'd1;
                if (gap_cnt_r == GAP_LAST) begin
                    load_s = throttle_ok_s;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_FIN: begin
                done_nx = 1'b1;
                busy_nx = 1'b0;
            end
            default: begin
                busy_nx = 1'b0;
            end
        endcase

        if (load_s) begin
            tvalid_nx   = 1'b1;
            tdata_nx    = pattern_f(frame_idx_r, beat_idx_r);
            tuser_nx    = '0;
            tuser_nx[0] = (beat_idx_r == 16'd0);
            tlast_nx    = is_last_s;
            tkeep_nx    = is_last_s ? last_keep_r : KEEP_ALL;
            if (is_last_s) begin
                beat_idx_nx  = 16'd0;
                frame_idx_nx = frame_idx_r + 16'd1;
            end else begin
                beat_idx_nx  = beat_idx_r + 16'd1;
                frame_idx_nx = frame_idx_r;
            end
        end else if (hs_s) begin
            tvalid_nx = 1'b0;
        end else begin
            tvalid_nx = tvalid_r;
        end
    end

    // Registered outputs, latched config and counters.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tvalid_r      <= 1'b0;
            tdata_r       <= '0;
            tkeep_r       <= '0;
            tlast_r       <= 1'b0;
            tuser_r       <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            frames_sent_r <= 16'd0;
            num_frames_r  <= 16'd0;
            beats_r       <= 16'd0;
            last_keep_r   <= '0;
            frame_idx_r   <= 16'd0;
            beat_idx_r    <= 16'd0;
            gap_cnt_r     <= 16'd0;
        end else begin
            tvalid_r      <= tvalid_nx;
            tdata_r       <= tdata_nx;
            tkeep_r       <= tkeep_nx;
            tlast_r       <= tlast_nx;
            tuser_r       <= tuser_nx;
            busy_r        <= busy_nx;
            done_r        <= done_nx;
            frames_sent_r <= frames_sent_nx;
            num_frames_r  <= num_frames_nx;
            beats_r       <= beats_nx;
            last_keep_r   <= last_keep_nx;
            frame_idx_r   <= frame_idx_nx;
            beat_idx_r    <= beat_idx_nx;
            gap_cnt_r     <= gap_cnt_nx;
        end
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tkeep  = tkeep_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tuser  = tuser_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign frames_sent   = frames_sent_r;

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed, table-driven bench for axis_frame_source (default parameters:
// 32-bit data, 4 keep bits, 2 idle cycles between frames).
module tb_axis_frame_source;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_frames = 16'd0;
    logic [15:0] frame_bytes = 16'd0;
    logic        busy, done;
    logic [15:0] frames_sent;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;

    axis_frame_source dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .num_frames    (num_frames),
        .frame_bytes   (frame_bytes),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    // 100 MHz clock.
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] bq_data[$];
    logic [3:0]  bq_keep[$];
    logic        bq_last[$];
    logic        bq_user[$];
    int          bq_cyc[$];

    typedef struct {
        logic [15:0] nf;
        logic [15:0] fb;
        int          rmode;
        int          beats;
        int          bpf;
        logic [3:0]  lk;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_tdata"}, m_axis_tdata, 32'd0);
        check({tag, "_tkeep"}, 32'(m_axis_tkeep), 32'd0);
        check({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
        check({tag, "_tuser"}, 32'(m_axis_tuser), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_frames_sent"}, 32'(frames_sent), 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input logic [15:0] nf, input logic [15:0] fb);
        num_frames  = nf;
        frame_bytes = fb;
        start       = 1'b1;
        @(negedge aclk);
        start       = 1'b0;
    endtask

    // Drives tready each cycle, records accepted beats, checks stability of
    // stalled beats, and stops on done (or flags a timeout).
    task automatic collect(input int rmode, input int budget);
        logic [31:0] p_data;
        logic [3:0]  p_keep;
        logic        p_last, p_user, p_stall, got_done;
        bq_data.delete(); bq_keep.delete(); bq_last.delete(); bq_user.delete(); bq_cyc.delete();
        p_stall  = 1'b0;
        got_done = 1'b0;
        p_data = 32'd0; p_keep = 4'd0; p_last = 1'b0; p_user = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (p_stall) begin
                check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
                check("hold_tdata", m_axis_tdata, p_data);
                check("hold_tkeep", 32'(m_axis_tkeep), 32'(p_keep));
                check("hold_tlast", 32'(m_axis_tlast), 32'(p_last));
                check("hold_tuser", 32'(m_axis_tuser), 32'(p_user));
            end
            m_axis_tready = (rmode == 0) ? 1'b1 : ((c % 2) == 1);
            p_stall = m_axis_tvalid && !m_axis_tready;
            p_data  = m_axis_tdata;
            p_keep  = m_axis_tkeep;
            p_last  = m_axis_tlast;
            p_user  = m_axis_tuser[0];
            if (m_axis_tvalid && m_axis_tready) begin
                bq_data.push_back(m_axis_tdata);
                bq_keep.push_back(m_axis_tkeep);
                bq_last.push_back(m_axis_tlast);
                bq_user.push_back(m_axis_tuser[0]);
                bq_cyc.push_back(c);
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        if (!got_done) begin
            check("done_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        vecs[0] = '{nf: 16'd2, fb: 16'd16, rmode: 0, beats: 8, bpf: 4, lk: 4'hF};
        vecs[1] = '{nf: 16'd1, fb: 16'd7,  rmode: 0, beats: 2, bpf: 2, lk: 4'h7};
        vecs[2] = '{nf: 16'd1, fb: 16'd3,  rmode: 0, beats: 1, bpf: 1, lk: 4'h7};
        vecs[3] = '{nf: 16'd1, fb: 16'd0,  rmode: 0, beats: 1, bpf: 1, lk: 4'hF};
        vecs[4] = '{nf: 16'd1, fb: 16'd10, rmode: 1, beats: 3, bpf: 3, lk: 4'h3};
        vecs[5] = '{nf: 16'd3, fb: 16'd5,  rmode: 0, beats: 6, bpf: 2, lk: 4'h1};

        // Reset state
        repeat (3) @(negedge aclk);
        check_all_zero("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        // Table-driven bursts
        for (int v = 0; v < 6; v++) begin
            do_start(vecs[v].nf, vecs[v].fb);
            check("busy_after_start", 32'(busy), 32'd1);
            check("tvalid_latency0", 32'(m_axis_tvalid), 32'd0);
            collect(vecs[v].rmode, 400);
            check("beat_count", 32'(bq_data.size()), 32'(vecs[v].beats));
            for (int i = 0; i < bq_data.size(); i++) begin
                int f, b;
                f = i / vecs[v].bpf;
                b = i % vecs[v].bpf;
                check("tdata", bq_data[i], {16'(f), 16'(b)});
                check("tkeep", 32'(bq_keep[i]), (b == vecs[v].bpf - 1) ? 32'(vecs[v].lk) : 32'hF);
                check("tlast", 32'(bq_last[i]), (b == vecs[v].bpf - 1) ? 32'd1 : 32'd0);
                check("tuser", 32'(bq_user[i]), (b == 0) ? 32'd1 : 32'd0);
                if (i == 0) begin
                    check("first_beat_cycle", 32'(bq_cyc[i]), 32'd1);
                end else if (vecs[v].rmode == 0) begin
                    check("beat_spacing", 32'(bq_cyc[i] - bq_cyc[i-1]), (b == 0) ? 32'd3 : 32'd1);
                end
            end
            check("frames_sent", 32'(frames_sent), 32'(vecs[v].nf));
            check("busy_at_done", 32'(busy), 32'd0);
            @(negedge aclk);
            check("done_one_cycle", 32'(done), 32'd0);
        end

        // Zero-frame burst; start coincident with done is ignored
        m_axis_tready = 1'b1;
        do_start(16'd0, 16'd16);
        check("nf0_busy", 32'(busy), 32'd1);
        check("nf0_tvalid_a", 32'(m_axis_tvalid), 32'd0);
        @(negedge aclk);
        check("nf0_done", 32'(done), 32'd1);
        check("nf0_busy_low", 32'(busy), 32'd0);
        check("nf0_tvalid_b", 32'(m_axis_tvalid), 32'd0);
        check("nf0_frames_sent", 32'(frames_sent), 32'd0);
        num_frames = 16'd1;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check("start_on_done_busy", 32'(busy), 32'd0);
        check("start_on_done_done", 32'(done), 32'd0);
        @(negedge aclk);
        check("start_on_done_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Start while busy is ignored
        m_axis_tready = 1'b0;
        do_start(16'd1, 16'd16);
        repeat (3) @(negedge aclk);
        check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("stall_tdata", m_axis_tdata, 32'h0000_0000);
        num_frames  = 16'd5;
        frame_bytes = 16'd4;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check("busy_start_busy", 32'(busy), 32'd1);
        collect(0, 100);
        check("busy_start_beats", 32'(bq_data.size()), 32'd4);
        if (bq_data.size() == 4) begin
            check("busy_start_last_data", bq_data[3], 32'h0000_0003);
        end
        check("busy_start_frames_sent", 32'(frames_sent), 32'd1);
        @(negedge aclk);

        // Reset in the middle of a frame
        m_axis_tready = 1'b1;
        do_start(16'd1, 16'd16);
        repeat (3) @(negedge aclk);
        check("midreset_beat2", m_axis_tdata, 32'h0000_0002);
        check("midreset_beat2_valid", 32'(m_axis_tvalid), 32'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        check_all_zero("midreset");
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        do_start(16'd1, 16'd16);
        collect(0, 100);
        check("restart_beats", 32'(bq_data.size()), 32'd4);
        if (bq_data.size() > 0) begin
            check("restart_first_data", bq_data[0], 32'h0000_0000);
            check("restart_first_user", 32'(bq_user[0]), 32'd1);
        end
        check("restart_frames_sent", 32'(frames_sent), 32'd1);
        @(negedge aclk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
